// File: rtl/msk_rnd_xorshift_feeder_if.sv
// Seed and randomness handshake bundle for the xorshift feeder.
// master = feeder side, slave = seed source / randomness consumer side.
interface msk_rnd_xorshift_feeder_if #(
   parameter int RND_W = 64
);
   logic             seed_valid;
   logic             seed_ready;
   logic [127:0]     seed_data;
   logic             rnd_valid;
   logic             rnd_ready;
   logic [RND_W-1:0] rnd_data;
   logic             busy;

   modport master (
      input  seed_valid,
      input  seed_data,
      input  rnd_ready,
      output seed_ready,
      output rnd_valid,
      output rnd_data,
      output busy
   );

   modport slave (
      output seed_valid,
      output seed_data,
      output rnd_ready,
      input  seed_ready,
      input  rnd_valid,
      input  rnd_data,
      input  busy
   );
endinterface

// File: rtl/msk_rnd_xorshift_feeder.sv
// Reseedable xorshift128 randomness feeder for the masked AES core.
// Warms up after each seed, then packs RND_W/32 steps MSB-first.
module msk_rnd_xorshift_feeder #(
   parameter int RND_W         = 64,
   parameter int WARMUP_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   msk_rnd_xorshift_feeder_if.master bus
);
   localparam int NW   = RND_W / 32;
   localparam int MAXC = (WARMUP_CYCLES > NW) ? WARMUP_CYCLES : NW;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [1:0] ST_UNSEEDED = 2'd0;
   localparam logic [1:0] ST_WARMUP   = 2'd1;
   localparam logic [1:0] ST_FILL     = 2'd2;
   localparam logic [1:0] ST_FULL     = 2'd3;

   localparam logic [127:0] SEED_DEF =
      128'h075BCD15_159A55E5_1F123BB5_05491333;

   localparam logic [CW-1:0] WARM_LAST =
      CW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
   localparam logic [CW-1:0] FILL_LAST = CW'(NW - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [127:0]     gen_q, gen_d;
   logic [RND_W-1:0] buf_q, buf_d;

   logic [31:0]  gx, gy, gz, gw, gt, step_w;
   logic [127:0] gen_step;
   logic         seed_fire;

   assign gx = gen_q[127:96];
   assign gy = gen_q[95:64];
   assign gz = gen_q[63:32];
   assign gw = gen_q[31:0];

   assign gt       = gx ^ (gx << 11);
   assign step_w   = gw ^ (gw >> 19) ^ gt ^ (gt >> 8);
   assign gen_step = {gy, gz, gw, step_w};

   assign bus.seed_ready = (state_q != ST_WARMUP);
   assign bus.rnd_valid  = (state_q == ST_FULL);
   assign bus.busy       = (state_q == ST_WARMUP) |
                           (state_q == ST_FILL);
   assign bus.rnd_data   = buf_q;

   assign seed_fire = bus.seed_valid & bus.seed_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gen_d   = gen_q;
      buf_d   = buf_q;
      unique case (state_q)
         ST_UNSEEDED: begin
            state_d = ST_UNSEEDED;
         end
         ST_WARMUP: begin
            gen_d = gen_step;
            if (cnt_q == WARM_LAST) begin
               cnt_d   = '0;
               state_d = ST_FILL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_FILL: begin
            gen_d = gen_step;
            buf_d = (buf_q << 32) | RND_W'(step_w);
            if (cnt_q == FILL_LAST) begin
               cnt_d   = '0;
               state_d = ST_FULL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_FULL: begin
            if (bus.rnd_ready) begin
               cnt_d   = '0;
               state_d = ST_FILL;
            end
         end
      endcase
      // A seed overrides any concurrent consumption or fill progress
      if (seed_fire) begin
         gen_d   = (bus.seed_data == '0) ? SEED_DEF : bus.seed_data;
         buf_d   = '0;
         cnt_d   = '0;
         state_d = (WARMUP_CYCLES == 0) ? ST_FILL : ST_WARMUP;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_UNSEEDED;
         cnt_q   <= '0;
         gen_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gen_q   <= gen_d;
         buf_q   <= buf_d;
      end
   end
endmodule

// File: doc/msk_rnd_xorshift_feeder.md
Name: msk_rnd_xorshift_feeder

Overview:
Randomness source that sits directly upstream of the masked AES core's randomness buses (rnd_bus0w..rnd_bus3w) and gates the core through in_ready_rnd. It holds a reseedable xorshift128 generator (32 bits per step), performs a configurable warm-up, and packs RND_W bits into an output buffer. The buffer is presented under a valid/ready handshake. The masking network's share randomness is sliced from rnd_data by the integration wrapper.

Parameters:
RND_W, 64, output word width in bits; multiple of 32, at least 32; NW = RND_W/32 generator steps per output word.
WARMUP_CYCLES, 16, generator steps discarded after every seed load; 0 is legal.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  reset, asynchronous and active-low.
seed_valid  in  1  seed offered.
seed_ready  out  1  seed can be accepted this cycle.
seed_data  in  128  seed; [127:96]=x, [95:64]=y, [63:32]=z, [31:0]=w.
rnd_valid  out  1  rnd_data holds a complete fresh word.
rnd_ready  in  1  consumer (core in_ready_rnd) takes rnd_data.
rnd_data  out  RND_W  random word.
busy  out  1  warm-up or fill in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to UNSEEDED, and the generator state and buffer are cleared to 0.
  - Fill counter and warm-up counter are cleared to 0.
  - Outputs: rnd_valid=0, rnd_data=0, busy=0, seed_ready=1.
  - Deassertion is sampled synchronously, with no special sequencing.
- Generator step: t=x^(x<<11); x'=y; y'=z; z'=w; w'=w^(w>>19)^t^(t>>8). The step output is w'. All operations are 32-bit and shifts are logical.
- Seed load: occurs when seed_valid&seed_ready at a clock edge.
  - The generator loads {x,y,z,w}=seed_data.
  - An all-zero seed is replaced by 128'h075BCD15_159A55E5_1F123BB5_05491333.
  - The buffer and fill counter are cleared, rnd_valid goes to 0 the next cycle, and the state becomes WARMUP (or FILL if WARMUP_CYCLES=0).
- States:
  - UNSEEDED: no stepping; seed_ready=1; busy=0; rnd_valid=0.
  - WARMUP: one step per cycle, output discarded. After WARMUP_CYCLES steps the state becomes FILL. seed_ready=0; busy=1.
  - FILL: one step per cycle; buffer <= {buffer[RND_W-33:0], w'}, so the first word ends up in the MSBs. After NW steps the state becomes FULL. seed_ready=1; busy=1.
  - FULL: no stepping; rnd_valid=1; rnd_data stable until consumed; seed_ready=1; busy=0.
- Consumption: rnd_valid&rnd_ready in FULL moves the state to FILL with the fill counter at 0.
  - rnd_valid is low for exactly NW cycles after the handshake cycle.
  - rnd_data keeps its old value until the next FULL; the consumer must rely only on rnd_valid.
- Simultaneous seed and consumption in FULL:
  - The seed wins: the state goes to WARMUP and the consumed word counts as taken.
  - No word is ever presented twice.
- Seed during FILL: the partial buffer is discarded and the block restarts from WARMUP.
- Latency from a seed handshake to the first rnd_valid: WARMUP_CYCLES+NW cycles.
- rnd_ready while rnd_valid=0 is ignored. rnd_valid never drops without a handshake, except on seed or reset.
- Reset mid-operation: immediate return to UNSEEDED; a seed is needed again.
- Counters are sized for max(WARMUP_CYCLES, NW) and never wrap.

Test Plan:
1. Seed (WARMUP_CYCLES=0, RND_W=64, seed = standard constant) -> rnd_valid after 2 cycles; rnd_data = 64'hDCA345EA_1B5116E6.
2. Seed with an all-zero seed_data, same config -> identical rnd_data to scenario 1.
3. Default parameters, random seeds, rnd_ready random -> every word matches the xorshift128 software model (16 steps discarded, then 2 steps packed, MSB-first), with no duplicates and no skips.
4. After FULL, rnd_ready=1 held -> rnd_valid low for exactly 2 cycles between handshakes; rnd_data held while rnd_ready=0 for 50 cycles.
5. seed_valid in the same cycle as a consumption handshake, and again mid-FILL -> next word equals the model restarted from the new seed; seed_ready is 0 for all WARMUP cycles.
6. Assert rst low mid-FILL, asynchronously between clock edges -> outputs go to reset values at once; no rnd_valid until a new seed.
